spi_updown_counter_ctrl: RTL and testbench

Parametrised, tick-driven up/down counter with a run-control FSM for the SPI stopwatch/timer display path.
Adds the following beyond a plain up-counter:
- selectable direction
- parallel load
- wrap or saturate-and-stop mode
- terminal-count pulse
- exported run state

Sits between the SPI control-register decode (runstop/clear/load/mode) and the display formatter that consumes counter.

---
 rtl/spi_updown_counter_ctrl.sv | 163 ++++++++++++++++
 tb/tb_spi_updown_counter_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_updown_counter_ctrl.sv
// rtl/spi_updown_counter_ctrl.sv - tick-driven up/down counter with run-control FSM
//
// Purpose: stopwatch/timer counter between the SPI control-register decode and
//          the display formatter. Counts 0..MAX_VAL up or down on single-cycle
//          ticks, with wrap or saturate-and-stop, parallel load, and a
//          terminal-count pulse.
// Optional: define SPI_COUNTER_BCD_EN to add a sequential binary-to-BCD
//           converter (o_bcd / o_bcd_valid). Requires MAX_VAL <= 9999.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_runstop         level run (1) / pause (0) request
//   i_clear           pulse: counter to 0, FSM to IDLE
//   i_load            pulse: counter <= min(i_load_val, MAX_VAL)
//   i_load_val        load value
//   i_dir             0 = up, 1 = down
//   i_wrap            1 = wrap at range ends, 0 = saturate and stop
//   tick              single-cycle count enable
//   counter           current count
//   o_tc              one-cycle terminal-step pulse, aligned with counter update
//   o_state           00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   o_bcd             (BCD option) last completed BCD conversion of counter
//   o_bcd_valid       (BCD option) low while a conversion is in progress
module spi_updown_counter_ctrl #(
    parameter int WIDTH   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_runstop,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dir,
    input  logic             i_wrap,
    input  logic             tick,
    output logic [WIDTH-1:0] counter,
    output logic             o_tc,
    output logic [1:0]       o_state
`ifdef SPI_COUNTER_BCD_EN
    ,
    output logic [15:0]      o_bcd,
    output logic             o_bcd_valid
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             tc_q, tc_d;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        tc_d    = 1'b0;
        if (i_clear) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else if (i_load) begin
            cnt_d   = (i_load_val > MAX_C) ? MAX_C : i_load_val;
            state_d = i_runstop ? ST_RUN : ST_PAUSE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    // Entering RUN does not count a coincident tick: counting
                    // is gated on the registered state.
                    if (i_runstop) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!i_runstop) state_d = ST_PAUSE;
                    if (tick) begin
                        if (!i_dir) begin
                            if (cnt_q < MAX_C) begin
                                cnt_d = cnt_q + 1'b1;
                            end else begin
                                tc_d = 1'b1;
                                if (i_wrap) cnt_d = '0;
                                else        state_d = ST_DONE;
                            end
                        end else begin
                            if (cnt_q != '0) begin
                                cnt_d = cnt_q - 1'b1;
                            end else begin
                                tc_d = 1'b1;
                                if (i_wrap) cnt_d = MAX_C;
                                else        state_d = ST_DONE;
                            end
                        end
                    end
                end
                default: ;  // DONE holds until clear, load or reset
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            tc_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    assign counter = cnt_q;
    assign o_tc    = tc_q;
    assign o_state = state_q;

`ifdef SPI_COUNTER_BCD_EN
    localparam int BW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sh_q;
    logic [15:0]      acc_q, adj, bcd_q;
    logic [BW-1:0]    bit_q;
    logic             busy_q;

    // Add 3 to every BCD digit >= 5 before the next left shift.
    always_comb begin
        adj = acc_q;
        for (int k = 0; k < 4; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
        end
    end

    // Start from cnt_d so the busy window lines up with the counter update:
    // WIDTH shift cycles plus one latch cycle. A new change restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q   <= '0;
            acc_q  <= '0;
            bcd_q  <= '0;
            bit_q  <= '0;
            busy_q <= 1'b0;
        end else if (cnt_d != cnt_q) begin
            sh_q   <= cnt_d;
            acc_q  <= '0;
            bit_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (bit_q == BW'(WIDTH)) begin
                bcd_q  <= acc_q;
                busy_q <= 1'b0;
            end else begin
                acc_q <= {adj[14:0], sh_q[WIDTH-1]};
                sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
                bit_q <= bit_q + 1'b1;
            end
        end
    end

    assign o_bcd       = bcd_q;
    assign o_bcd_valid = !busy_q;
`endif

endmodule

// File: tb/tb_spi_updown_counter_ctrl.sv
// tb/tb_spi_updown_counter_ctrl.sv - directed self-checking bench for spi_updown_counter_ctrl
module tb_spi_updown_counter_ctrl;

    localparam int WIDTH   = 14;
    localparam int MAX_VAL = 9999;
    localparam int IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             i_runstop = 1'b0;
    logic             i_clear = 1'b0;
    logic             i_load = 1'b0;
    logic [WIDTH-1:0] i_load_val = '0;
    logic             i_dir = 1'b0;
    logic             i_wrap = 1'b0;
    logic             tick = 1'b0;
    logic [WIDTH-1:0] counter;
    logic             o_tc;
    logic [1:0]       o_state;
`ifdef SPI_COUNTER_BCD_EN
    logic [15:0]      o_bcd;
    logic             o_bcd_valid;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int tc_seen;

    always #5 clk = ~clk;

    spi_updown_counter_ctrl #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_runstop  (i_runstop),
        .i_clear    (i_clear),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .i_dir      (i_dir),
        .i_wrap     (i_wrap),
        .tick       (tick),
        .counter    (counter),
        .o_tc       (o_tc),
        .o_state    (o_state)
`ifdef SPI_COUNTER_BCD_EN
        ,
        .o_bcd      (o_bcd),
        .o_bcd_valid(o_bcd_valid)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk(input string tag, input int exp_cnt, input int exp_tc);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check({tag, "_cnt"}, int'(counter), exp_cnt);
        check({tag, "_tc"}, int'(o_tc), exp_tc);
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_cnt", int'(counter), 0);
        check("rst_tc", int'(o_tc), 0);
        check("rst_state", int'(o_state), IDLE);
`ifdef SPI_COUNTER_BCD_EN
        check("rst_bcd", int'(o_bcd), 0);
        check("rst_bcd_valid", int'(o_bcd_valid), 1);
`endif
        reset = 1'b0;

        // 1: count up 12 ticks, then pause
        i_runstop = 1'b1;
        step();
        check("t1_run", int'(o_state), RUN);
        tc_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (o_tc) tc_seen++;
        end
        check("t1_cnt12", int'(counter), 12);
        check("t1_no_tc", tc_seen, 0);
        i_runstop = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
        check("t1_pause_cnt", int'(counter), 12);
        check("t1_pause_state", int'(o_state), PAUSE);

        // 2: wrap at top
        i_load_val = WIDTH'(9998); i_load = 1'b1; i_runstop = 1'b1; i_wrap = 1'b1; i_dir = 1'b0;
        step();
        i_load = 1'b0;
        check("t2_load", int'(counter), 9998);
        check("t2_state", int'(o_state), RUN);
        tick_chk("t2_a", 9999, 0);
        tick_chk("t2_b", 0, 1);
        tick_chk("t2_c", 1, 0);

        // 3: count down, saturate, DONE
        i_load_val = WIDTH'(2); i_load = 1'b1; i_dir = 1'b1; i_wrap = 1'b0;
        step();
        i_load = 1'b0;
        tick_chk("t3_a", 1, 0);
        tick_chk("t3_b", 0, 0);
        tick_chk("t3_c", 0, 1);
        check("t3_done", int'(o_state), DONE);
        tick_chk("t3_d", 0, 0);
        i_runstop = 1'b0;
        step();
        check("t3_hold0", int'(o_state), DONE);
        i_runstop = 1'b1;
        step();
        check("t3_hold1", int'(o_state), DONE);
        i_runstop = 1'b0; i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check("t3_clr_cnt", int'(counter), 0);
        check("t3_clr_state", int'(o_state), IDLE);

        // 4: clamp over-range load; clear beats load and tick
        i_load_val = WIDTH'(16000); i_load = 1'b1;
        step();
        i_load = 1'b0;
        check("t4_clamp", int'(counter), MAX_VAL);
        check("t4_state", int'(o_state), PAUSE);
        i_runstop = 1'b1;
        step();
        i_clear = 1'b1; i_load = 1'b1; i_load_val = WIDTH'(77); tick = 1'b1; i_runstop = 1'b0;
        step();
        i_clear = 1'b0; i_load = 1'b0; tick = 1'b0;
        check("t4_clr_cnt", int'(counter), 0);
        check("t4_clr_state", int'(o_state), IDLE);
        check("t4_clr_tc", int'(o_tc), 0);

        // 5: reset mid-run with tick held, then restart
        i_load_val = WIDTH'(50); i_load = 1'b1; i_runstop = 1'b1; i_dir = 1'b0;
        step();
        i_load = 1'b0;
        check("t5_run50", int'(counter), 50);
        reset = 1'b1; tick = 1'b1;
        step();
        check("t5_rst_cnt", int'(counter), 0);
        check("t5_rst_state", int'(o_state), IDLE);
        check("t5_rst_tc", int'(o_tc), 0);
        step();
        check("t5_rst_hold", int'(counter), 0);
        reset = 1'b0;
        step();
        check("t5_enter_run", int'(o_state), RUN);
        check("t5_no_count", int'(counter), 0);
        step();
        check("t5_first", int'(counter), 1);
        tick = 1'b0;

        // Direction/wrap change between ticks: down-wrap at zero
        i_dir = 1'b1; i_wrap = 1'b1;
        step();
        tick_chk("t5_dn", 0, 0);
        tick_chk("t5_wrap", MAX_VAL, 1);

`ifdef SPI_COUNTER_BCD_EN
        // 6: BCD conversion of 1234
        i_runstop = 1'b0; i_load_val = WIDTH'(1234); i_load = 1'b1;
        step();
        i_load = 1'b0;
        tc_seen = 0;
        for (int i = 0; i < WIDTH + 1; i++) begin
            if (o_bcd_valid) tc_seen++;
            step();
        end
        check("t6_busy", tc_seen, 0);
        check("t6_valid", int'(o_bcd_valid), 1);
        check("t6_bcd", int'(o_bcd), 'h1234);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
